// File: rtl/serial_tx_if.sv
// serial_tx_if
//   Bundles the parallel-load request and the serial line outputs of
//   serial_tx so a producer and the transmitter can be wired with one port.
//
//   Handshake: the producer raises load with data valid. The transmitter
//   takes the request on a rising clk edge only while busy is low (this
//   includes the single done cycle). Requests seen while busy is high are
//   dropped, not queued. There is no separate ready; busy=0 is the ready.
//
//   Signals
//     data      payload, sampled only on the accepting edge
//     load      frame request
//     sout      serial line, idles high
//     sout_n    complement of sout
//     busy      high for every cycle of a frame
//     done      one-cycle pulse in the first idle cycle after a frame
//     dbg_state current FSM state, for observation only
//
//   Modports: master = producer / observer, slave = serial_tx.
interface serial_tx_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] data;
   logic              load;
   logic              sout;
   logic              sout_n;
   logic              busy;
   logic              done;
   logic [2:0]        dbg_state;

   modport master (
      output data,
      output load,
      input  sout,
      input  sout_n,
      input  busy,
      input  done,
      input  dbg_state
   );

   modport slave (
      input  data,
      input  load,
      output sout,
      output sout_n,
      output busy,
      output done,
      output dbg_state
   );
endinterface

// File: rtl/serial_tx.sv
// serial_tx
//   Parallel-in, serial-out frame transmitter. A frame is one start bit (0),
//   DATA_W payload bits LSB first, an optional even-parity bit, and one stop
//   bit (1). Every bit is held for BIT_CYC clock cycles.
//
//   Parameters
//     DATA_W   payload bits per frame, 1..16
//     BIT_CYC  clock cycles per serial bit, 1..255
//
//   Ports
//     clk  rising-edge clock
//     rst  asynchronous, active-high reset
//     bus  serial_tx_if.slave: data/load in; sout/sout_n/busy/done out;
//          dbg_state exposes the FSM state
//
//   Build option
//     SERIAL_TX_PARITY_EN  when defined, a PARITY state is inserted between
//                          DATA and STOP carrying the XOR of the payload.
module serial_tx #(
   parameter int DATA_W  = 8,
   parameter int BIT_CYC = 1
) (
   input  logic       clk,
   input  logic       rst,
   serial_tx_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(BIT_CYC - 1);
   localparam logic [3:0] IDX_LAST = 4'(DATA_W - 1);

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;     // cycles spent in the current bit
   logic [3:0]        idx_q, idx_d;     // payload bit being sent
   logic [DATA_W-1:0] shreg_q, shreg_d; // captured payload, held for the frame
   logic              sout_q, sout_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [15:0]       payload;
   logic              bit_end;

   // Zero-extend to 16 bits so a 4-bit index is always in range, whatever
   // DATA_W is.
   assign payload = 16'(shreg_q);
   assign bit_end = (cnt_q == CNT_LAST);

   // Outputs are computed for the cycle after the edge and registered, so the
   // line level always lines up with the state it belongs to.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      sout_d  = 1'b1;
      busy_d  = 1'b1;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (bus.load) begin
               shreg_d = bus.data;
               cnt_d   = '0;
               idx_d   = '0;
               state_d = START;
               sout_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end

         START: begin
            sout_d = 1'b0;
            if (bit_end) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = DATA;
               sout_d  = payload[0];
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         DATA: begin
            sout_d = payload[idx_q];
            if (bit_end) begin
               cnt_d = '0;
               if (idx_q == IDX_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                  state_d = PARITY;
                  sout_d  = ^shreg_q;
`else
                  state_d = STOP;
                  sout_d  = 1'b1;
`endif
               end else begin
                  idx_d  = idx_q + 4'd1;
                  sout_d = payload[idx_q + 4'd1];
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

`ifdef SERIAL_TX_PARITY_EN
         PARITY: begin
            sout_d = ^shreg_q;
            if (bit_end) begin
               cnt_d   = '0;
               state_d = STOP;
               sout_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
`endif

         STOP: begin
            sout_d = 1'b1;
            if (bit_end) begin
               cnt_d   = '0;
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         default: begin
            // Unused encodings fall back to an idle line on the next edge.
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         sout_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         sout_q  <= sout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.sout      = sout_q;
   assign bus.sout_n    = ~sout_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx
//   Drives two serial_tx instances (BIT_CYC 1 and 3, DATA_W 8) with the same
//   load/data stream. A frame-level model turns each accepted load into the
//   list of (sout, busy, done) values for the following cycles; every cycle
//   both instances are compared against it. Literal frames pin the model.
//   Honours SERIAL_TX_PARITY_EN the same way the design does.
module tb_serial_tx;
   localparam int DW  = 8;
   localparam int BC0 = 1;
   localparam int BC1 = 3;
`ifdef SERIAL_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   typedef struct packed {
      logic sout;
      logic busy;
      logic done;
   } ent_t;

   localparam ent_t IDLE_E = '{sout: 1'b1, busy: 1'b0, done: 1'b0};

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   serial_tx_if #(.DATA_W(DW)) if0 ();
   serial_tx_if #(.DATA_W(DW)) if1 ();

   serial_tx #(.DATA_W(DW), .BIT_CYC(BC0)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0.slave)
   );

   serial_tx #(.DATA_W(DW), .BIT_CYC(BC1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1.slave)
   );

   // ---------------- scoreboard state ----------------
   ent_t q0[$];
   ent_t q1[$];
   ent_t cur [2];
   logic so_now [2];
   logic bu_now [2];
   logic dn_now [2];
   int   n_pass;
   int   n_total;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Expected per-cycle values of one whole frame plus its done cycle.
   task automatic push_frame(input int l, input logic [DW-1:0] d);
      logic bits[$];
      int   bc;
      ent_t e;
      bc = (l == 0) ? BC0 : BC1;
      bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) bits.push_back(d[i]);
      if (PB == 1) bits.push_back(^d);
      bits.push_back(1'b1);
      foreach (bits[i]) begin
         for (int c = 0; c < bc; c++) begin
            e = '{sout: bits[i], busy: 1'b1, done: 1'b0};
            if (l == 0) q0.push_back(e);
            else        q1.push_back(e);
         end
      end
      e = '{sout: 1'b1, busy: 1'b0, done: 1'b1};
      if (l == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic model_clear();
      q0.delete();
      q1.delete();
      cur[0] = IDLE_E;
      cur[1] = IDLE_E;
   endtask

   task automatic compare_now();
      logic exp_n;
      logic act_n;
      so_now[0] = if0.sout; bu_now[0] = if0.busy; dn_now[0] = if0.done;
      so_now[1] = if1.sout; bu_now[1] = if1.busy; dn_now[1] = if1.done;
      for (int l = 0; l < 2; l++) begin
         act_n = (l == 0) ? if0.sout_n : if1.sout_n;
         exp_n = ~cur[l].sout;
         check($sformatf("sout lane%0d", l),   64'(so_now[l]), 64'(cur[l].sout));
         check($sformatf("busy lane%0d", l),   64'(bu_now[l]), 64'(cur[l].busy));
         check($sformatf("done lane%0d", l),   64'(dn_now[l]), 64'(cur[l].done));
         check($sformatf("sout_n lane%0d", l), 64'(act_n),     64'(exp_n));
      end
   endtask

   // ---------------- driver ----------------
   // Inputs change on the falling edge; the model advances at the rising
   // edge; outputs are compared at the next falling edge.
   task automatic step(input logic ld, input logic [DW-1:0] d);
      if0.load = ld; if0.data = d;
      if1.load = ld; if1.data = d;
      @(posedge clk);
      if (rst) begin
         model_clear();
      end else begin
         if (!cur[0].busy && ld) push_frame(0, d);
         if (!cur[1].busy && ld) push_frame(1, d);
         cur[0] = (q0.size() > 0) ? q0.pop_front() : IDLE_E;
         cur[1] = (q1.size() > 0) ? q1.pop_front() : IDLE_E;
      end
      @(negedge clk);
      compare_now();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0);
   endtask

   // Asynchronous reset pulse placed between edges; outputs must go idle
   // immediately, without waiting for a clock.
   task automatic pulse_rst();
      #2 rst = 1'b1;
      #1;
      model_clear();
      check("rst sout immediate",   64'(if0.sout),   64'd1);
      check("rst sout_n immediate", 64'(if0.sout_n), 64'd0);
      check("rst busy immediate",   64'(if0.busy),   64'd0);
      check("rst done immediate",   64'(if0.done),   64'd0);
      check("rst busy1 immediate",  64'(if1.busy),   64'd0);
      step(1'b1, 8'h3C);
      rst = 1'b0;
   endtask

   // Load d from idle, record lane's sout for len cycles, then check done.
   task automatic capture(input logic [DW-1:0] d, input int lane, input int len,
                          output logic [63:0] got, output int nbusy);
      got   = '0;
      nbusy = 0;
      for (int k = 0; k < len; k++) begin
         step(k == 0, d);
         got   = {got[62:0], so_now[lane]};
         nbusy = nbusy + int'(bu_now[lane]);
      end
      step(1'b0, '0);
      check($sformatf("done after frame lane%0d", lane), 64'(dn_now[lane]), 64'd1);
      step(1'b0, '0);
      check($sformatf("done single cycle lane%0d", lane), 64'(dn_now[lane]), 64'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [63:0] got;
      int          nb;
      int          len0;
      int          len1;

      n_pass  = 0;
      n_total = 0;
      len0    = (DW + 2 + PB) * BC0;
      len1    = (DW + 2 + PB) * BC1;
      rst     = 1'b1;
      if0.load = 1'b0; if0.data = '0;
      if1.load = 1'b0; if1.data = '0;
      model_clear();

      // Reset holds the line idle even with load asserted.
      step(1'b1, 8'hFF);
      step(1'b1, 8'h11);
      check("reset sout",   64'(if0.sout),   64'd1);
      check("reset sout_n", 64'(if0.sout_n), 64'd0);
      rst = 1'b0;
      idle(3);

      // 8'hA5 on the single-cycle lane.
      capture(8'hA5, 0, len0, got, nb);
`ifdef SERIAL_TX_PARITY_EN
      check("A5 frame", got, 64'(11'b01010010101));
`else
      check("A5 frame", got, 64'(10'b0101001011));
`endif
      check("A5 busy cycles", 64'(nb), 64'(len0));
      idle(40);

      // 8'h01: parity bit is 1 when enabled.
      capture(8'h01, 0, len0, got, nb);
`ifdef SERIAL_TX_PARITY_EN
      check("01 frame", got, 64'(11'b01000000011));
`else
      check("01 frame", got, 64'(10'b0100000001));
`endif
      idle(40);

      // 8'h80 on the three-cycle lane.
      capture(8'h80, 1, len1, got, nb);
`ifdef SERIAL_TX_PARITY_EN
      check("80 frame bc3", got, 64'(33'h1FF));
`else
      check("80 frame bc3", got, 64'(30'h3F));
`endif
      check("80 busy cycles bc3", 64'(nb), 64'(len1));
      idle(40);

      // Load held high with data changing every cycle.
      for (int i = 0; i < 80; i++) step(1'b1, DW'($urandom));
      idle(40);

      // Abort an 8'hFF frame in its fifth cycle, then send a clean 8'h00.
      step(1'b1, 8'hFF);
      idle(4);
      pulse_rst();
      capture(8'h00, 0, len0, got, nb);
`ifdef SERIAL_TX_PARITY_EN
      check("00 after abort", got, 64'(11'b00000000001));
`else
      check("00 after abort", got, 64'(10'b0000000001));
`endif
      idle(40);

      // Random traffic with occasional reset pulses.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 149) == 0) pulse_rst();
         else step($urandom_range(0, 3) == 0, DW'($urandom));
      end
      idle(40);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
